// File: rtl/boron_round_ctrl.sv
// rtl/boron_round_ctrl.sv - iterative round sequencer for the BORON 64-bit block datapath
// Optional decrypt indexing is enabled by defining BORON_ROUND_CTRL_DECRYPT_EN.
module boron_round_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_ROUNDS = 25,
    parameter int RND_W      = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_block,
    output logic [DATA_WIDTH-1:0] o_rf_state,
    input  logic [DATA_WIDTH-1:0] i_rf_next,
    input  logic [DATA_WIDTH-1:0] i_fin_next,
    output logic [RND_W-1:0]      o_rnd_idx,
    output logic                  o_ks_load,
    output logic                  o_ks_step,
    output logic                  o_busy,
    output logic                  o_valid,
    input  logic                  i_ready,
`ifdef BORON_ROUND_CTRL_DECRYPT_EN
    input  logic                  i_decrypt,
`endif
    output logic [DATA_WIDTH-1:0] o_block
);

    localparam logic [RND_W-1:0] IDX_ZERO = '0;
    localparam logic [RND_W-1:0] IDX_TOP  = RND_W'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] state_reg;
    logic [RND_W-1:0]      rnd_idx;
    logic                  accept;
    logic                  decrypt_mode;
    logic                  accept_decrypt;
    logic [RND_W-1:0]      first_idx;
    logic [RND_W-1:0]      last_idx;

`ifdef BORON_ROUND_CTRL_DECRYPT_EN
    // Mode flag is captured with the block and held for the whole run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            decrypt_mode <= 1'b0;
        end else if (accept) begin
            decrypt_mode <= i_decrypt;
        end
    end
    assign accept_decrypt = i_decrypt;
`else
    assign decrypt_mode   = 1'b0;
    assign accept_decrypt = 1'b0;
`endif

    assign accept    = i_valid & o_ready;
    assign first_idx = accept_decrypt ? IDX_TOP : IDX_ZERO;
    assign last_idx  = decrypt_mode ? IDX_ZERO : IDX_TOP;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ROUND;
            ROUND:   if (rnd_idx == last_idx) state_next = FINAL;
            FINAL:   state_next = DONE;
            DONE:    if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready   = (state == IDLE);
        o_valid   = (state == DONE);
        o_busy    = (state != IDLE);
        o_ks_step = (state == ROUND);
        o_ks_load = i_valid & (state == IDLE);
    end

    // Datapath: block register and round index; index holds through FINAL and DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= '0;
            rnd_idx   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state_reg <= i_block;
                    rnd_idx   <= first_idx;
                end
                ROUND: begin
                    state_reg <= i_rf_next;
                    if (rnd_idx != last_idx) begin
                        rnd_idx <= decrypt_mode ? rnd_idx - 1'b1 : rnd_idx + 1'b1;
                    end
                end
                FINAL: state_reg <= i_fin_next;
                DONE:  if (i_ready) rnd_idx <= '0;
                default: ;
            endcase
        end
    end

    assign o_rf_state = state_reg;
    assign o_block    = state_reg;
    assign o_rnd_idx  = rnd_idx;

endmodule

// File: tb/tb_boron_round_ctrl.sv
// tb/tb_boron_round_ctrl.sv - scoreboard bench for boron_round_ctrl with a rotate/xor round stub
module tb_boron_round_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_block;
    logic [63:0] o_rf_state;
    logic [63:0] i_rf_next;
    logic [63:0] i_fin_next;
    logic [4:0]  o_rnd_idx;
    logic        o_ks_load;
    logic        o_ks_step;
    logic        o_busy;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_block;
    logic        dec_mode;

    int checks;
    int failures;
    logic [63:0] sb[$];

    boron_round_ctrl dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_block    (i_block),
        .o_rf_state (o_rf_state),
        .i_rf_next  (i_rf_next),
        .i_fin_next (i_fin_next),
        .o_rnd_idx  (o_rnd_idx),
        .o_ks_load  (o_ks_load),
        .o_ks_step  (o_ks_step),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
`ifdef BORON_ROUND_CTRL_DECRYPT_EN
        .i_decrypt  (dec_mode),
`endif
        .o_block    (o_block)
    );

    assign i_rf_next  = {o_rf_state[62:0], o_rf_state[63]};
    assign i_fin_next = o_rf_state ^ 64'h7EF5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [63:0] blk);
        logic [63:0] s;
        s = blk;
        for (int r = 0; r < 25; r++) s = {s[62:0], s[63]};
        return s ^ 64'h7EF5;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: settle, record handshakes into the scoreboard, advance to 1 after the edge.
    task automatic tick();
        #2;
        if (i_valid && o_ready) sb.push_back(model(i_block));
        if (o_valid && i_ready) begin
            if (sb.size() == 0) check("sb_spurious", {63'd0, o_valid}, 64'd0);
            else check("sb_block", o_block, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 40 && !o_valid; n++) tick();
        check(tag, {63'd0, o_valid}, 64'd1);
    endtask

    // Full walk of one block, checking every index step and the exact latency.
    task automatic run_walk(input logic [63:0] blk, input logic dec);
        i_valid  = 1'b1;
        i_block  = blk;
        dec_mode = dec;
        i_ready  = 1'b1;
        #1;
        check("walk_load", {63'd0, o_ks_load}, 64'd1);
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            check("walk_idx", {59'd0, o_rnd_idx}, dec ? 64'(24 - k) : 64'(k));
            check("walk_step", {63'd0, o_ks_step}, 64'd1);
            check("walk_early_valid", {63'd0, o_valid}, 64'd0);
            tick();
        end
        check("final_step", {63'd0, o_ks_step}, 64'd0);
        check("final_idx", {59'd0, o_rnd_idx}, dec ? 64'd0 : 64'd24);
        check("final_valid", {63'd0, o_valid}, 64'd0);
        tick();
        check("latency26_valid", {63'd0, o_valid}, 64'd1);
        check("done_block", o_block, 64'h0000_0000_0200_7EF5 ^ (blk == 64'h1 ? 64'd0 : model(blk) ^ 64'h0000_0000_0200_7EF5));
        tick();
        check("walk_ready_after", {63'd0, o_ready}, 64'd1);
        check("walk_idx_cleared", {59'd0, o_rnd_idx}, 64'd0);
    endtask

    initial begin
        logic [63:0] blk_a;
        logic [63:0] blk_b;
        logic [63:0] exp_bp;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_block  = '0;
        i_ready  = 1'b1;
        dec_mode = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", {63'd0, o_ready}, 64'd1);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_step", {63'd0, o_ks_step}, 64'd0);
        check("rst_load", {63'd0, o_ks_load}, 64'd0);
        check("rst_idx", {59'd0, o_rnd_idx}, 64'd0);
        check("rst_state", o_rf_state, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: encrypt of 64'h1
        run_walk(64'h1, 1'b0);

        // Test 2: backpressure in DONE
        blk_a   = {$urandom, $urandom};
        exp_bp  = model(blk_a);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_block = blk_a;
        tick();
        i_valid = 1'b0;
        wait_valid("bp_reach_done");
        for (int n = 0; n < 10; n++) begin
            check("bp_valid", {63'd0, o_valid}, 64'd1);
            check("bp_block", o_block, exp_bp);
            tick();
        end
        i_ready = 1'b1;
        tick();
        check("bp_ready_next", {63'd0, o_ready}, 64'd1);
        check("bp_valid_drop", {63'd0, o_valid}, 64'd0);

        // Test 3: back-to-back with i_valid held
        blk_a   = {$urandom, $urandom};
        blk_b   = {$urandom, $urandom};
        i_valid = 1'b1;
        i_block = blk_a;
        tick();
        i_block = blk_b;
        for (int n = 0; n < 40 && !o_valid; n++) begin
            check("b2b_no_load_busy", {63'd0, o_ks_load}, 64'd0);
            tick();
        end
        check("b2b_first_done", {63'd0, o_valid}, 64'd1);
        tick();
        check("b2b_ready_1cyc", {63'd0, o_ready}, 64'd1);
        check("b2b_load_1cyc", {63'd0, o_ks_load}, 64'd1);
        tick();
        i_valid = 1'b0;
        wait_valid("b2b_second_done");
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Test 4: reset mid-round
        i_valid = 1'b1;
        i_block = {$urandom, $urandom};
        tick();
        i_valid = 1'b0;
        for (int n = 0; n < 12; n++) tick();
        check("mid_idx12", {59'd0, o_rnd_idx}, 64'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {63'd0, o_busy}, 64'd0);
        check("mid_rst_valid", {63'd0, o_valid}, 64'd0);
        check("mid_rst_idx", {59'd0, o_rnd_idx}, 64'd0);
        check("mid_rst_ready", {63'd0, o_ready}, 64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_walk(64'h1, 1'b0);

`ifdef BORON_ROUND_CTRL_DECRYPT_EN
        // Test 5: decrypt indexing, then encrypt again
        run_walk(64'h1, 1'b1);
        run_walk(64'h1, 1'b0);
`endif

        check("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
